// File: rtl/df_cfnp_pkg.sv
// Shared defaults and FSM state encoding for the dataflow weight fetcher.
package df_cfnp_pkg;

  localparam int unsigned NUM_W_DEF = 5;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned AW_DEF    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/df_weight_fetcher.sv
// Fetches a clamped number of weights from a handshaking weight memory and
// presents them one at a time on a registered valid/ready output.
module df_weight_fetcher
  import df_cfnp_pkg::*;
#(
  parameter int unsigned NUM_W = NUM_W_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [AW-1:0]        num_filters,
  output logic                 mem_start,
  output logic [AW-1:0]        mem_index,
  input  logic signed [DW-1:0] mem_w,
  input  logic                 mem_done,
  output logic signed [DW-1:0] w_out,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic                 w_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [AW-1:0] NUM_W_A = AW'(NUM_W);

  state_t                state, state_nx;
  logic [AW-1:0]         idx, idx_nx;
  logic [AW-1:0]         count, count_nx;
  logic signed [DW-1:0]  w_out_nx;
  logic                  w_valid_nx, w_last_nx;

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      count   <= '0;
      w_out   <= '0;
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      count   <= count_nx;
      w_out   <= w_out_nx;
      w_valid <= w_valid_nx;
      w_last  <= w_last_nx;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    count_nx   = count;
    w_out_nx   = w_out;
    w_valid_nx = w_valid;
    w_last_nx  = w_last;
    unique case (state)
      IDLE: begin
        if (req) begin
          count_nx = (num_filters == '0 || num_filters > NUM_W_A) ? NUM_W_A : num_filters;
          idx_nx   = '0;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (mem_done) begin
          w_out_nx   = mem_w;
          w_valid_nx = 1'b1;
          w_last_nx  = (idx == count - AW'(1));
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        if (w_valid && w_ready) begin
          w_valid_nx = 1'b0;
          if (w_last) begin
            w_last_nx = 1'b0;
            state_nx  = FIN;
          end else begin
            idx_nx   = idx + AW'(1);
            state_nx = FETCH;
          end
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory request and status outputs decoded from the current state.
  always_comb begin
    mem_start = (state == FETCH);
    mem_index = (state == FETCH) ? idx : '0;
    busy      = (state != IDLE);
    done      = (state == FIN);
  end

endmodule
